free_addr_mgr: RTL
==================

// Module: free_addr_mgr
// PURPOSE
//  Free-list manager for the shared packet SRAM. Holds every unused 12-bit block
//  address. Hands one address per valid/ready handshake to the unpack stage
//  (drives its iEptyAddr/iEptyAddrVld, consumes its oEptyAddrRcvRdy).
//  Takes back addresses released by the egress read path after a block is read out.
// PARAMETERS
//  AW     12         block address width
//  DEPTH  (1<<AW)    number of managed blocks; power of two, >= 4
// PORTS
//  iClk             in   1     single clock
//  iRst             in   1     reset, asynchronous assert, active-high
//  oEptyAddr        out  AW    free block address offered to unpack
//  oEptyAddrVld     out  1     oEptyAddr is valid
//  iEptyAddrRcvRdy  in   1     unpack accepts the address; pop = Vld & Rdy
//  iFreeAddr        in   AW    released block address from egress
//  iFreeAddrVld     in   1     release request
//  oFreeAddrRdy     out  1     release accepted; push = Vld & Rdy
//  oFreeCnt         out  AW+1  free addresses held (RAM plus output register)
//  oInitDone        out  1     high from the end of INIT until the next reset
//  oOvfErr          out  1     sticky: a release was attempted while full
// BEHAVIOUR
//  - Reset (any time, including mid-operation): state=INIT, pointers=0, all
//    outputs 0 (oEptyAddr=0, Vld=0, oFreeAddrRdy=0, oFreeCnt=0, oInitDone=0,
//    oOvfErr=0). Any in-flight handshake is abandoned.
//  - FSM INIT -> RUN. No other states.
//  - INIT: an init counter i runs 0..DEPTH-1 and writes ram[i]=i, one per cycle.
//    After the i=DEPTH-1 write: wr_ptr=0 (wrapped), count=DEPTH, state=RUN.
//    oInitDone rises in the same cycle as RUN.
//  - INIT: oEptyAddrVld=0 and oFreeAddrRdy=0. Releases presented during INIT
//    wait (they are not dropped).
//  - RUN, circular FIFO in a sync RAM:
//    rd_ptr/wr_ptr are AW bits and wrap naturally.
//    ram_cnt is AW+1 bits. oFreeCnt = ram_cnt + oEptyAddrVld.
//  - Prefetch: issue a RAM read at rd_ptr when ram_cnt!=0 and the output
//    register is (empty | popping this cycle). Then rd_ptr++ and ram_cnt--.
//    The data loads the output register next cycle and sets Vld.
//    So back-to-back pops give one address per cycle.
//  - Latency: first Vld comes 1 cycle after oInitDone rises. Fresh allocation
//    order after reset is 0,1,2,...,DEPTH-1.
//  - Empty (ram_cnt=0): after a pop with no refill, Vld drops the next cycle.
//    Vld never re-asserts without a release.
//  - oEptyAddr/Vld hold steady while Vld & !Rdy (no change and no drop).
//  - oFreeAddrRdy = RUN & (oFreeCnt < DEPTH). A push writes ram[wr_ptr], then
//    wr_ptr++ and ram_cnt++.
//  - Release into an empty manager: push at cycle N gives a read at N+1 and
//    Vld at N+2.
//  - Simultaneous push and prefetch read in the same cycle: ram_cnt is
//    unchanged. Read/write to the same RAM word cannot occur, because reads
//    need ram_cnt>=1.
//  - Full (oFreeCnt==DEPTH): a release means a double free.
//    oFreeAddrRdy=0 and oOvfErr sets. The address is not stored. oOvfErr is
//    cleared only by reset.
//  - No duplicate-address checking beyond the full condition.
// STRUCTURE
//  - Shared package: FA_AW, FA_DEPTH, state encodings FA_INIT/FA_RUN.
//    Unpack and egress take the address width from the same constant.
//  - Sub-module free_addr_ram: simple dual-port sync RAM, DEPTH x AW.
//    One write port, one read port, 1-cycle registered read, no reset on the
//    array.
//  - Top level holds: FSM, init counter, pointers, ram_cnt, output register,
//    error flag.
// TESTING  (DEPTH=16 for speed, plus one run at 4096 for init length)
//  1. Release iRst; hold Rdy=1 -> oInitDone rises 16 cycles after reset
//     release. Vld the next cycle. Addresses 0..15 come on 16 consecutive
//     cycles, then Vld=0 and oFreeCnt=0.
//  2. Empty manager; push iFreeAddr=7 at cycle N -> Vld=1 with oEptyAddr=7 at
//     N+2. oFreeCnt = 1 from N+1 onward.
//  3. Vld=1, Rdy=0 for 10 cycles -> oEptyAddr is stable. Rdy=1 for one cycle
//     -> the next address appears next cycle, and oFreeCnt drops by 1.
//  4. oFreeCnt=8, push and pop in the same cycle for 20 cycles -> oFreeCnt
//     stays 8. Popped order equals pushed order (FIFO).
//  5. After init (full), drive iFreeAddrVld=1 addr=3 -> oFreeAddrRdy=0.
//     oOvfErr=1 next cycle and stays 1. oFreeCnt=16.
//  6. Assert iRst mid-stream (oFreeCnt=5, Vld=1) -> all outputs 0
//     immediately. On release, INIT repeats and allocation restarts at 0.

Source files
------------

// File: rtl/free_addr_mgr_pkg.sv
// Shared constants for the packet SRAM free-list manager.
// Unpack and egress size their block address ports from FA_AW.
package free_addr_mgr_pkg;
  localparam int FA_AW    = 12;
  localparam int FA_DEPTH = 1 << FA_AW;

  typedef enum logic {
    FA_INIT = 1'b0,
    FA_RUN  = 1'b1
  } fa_state_e;
endpackage

// File: rtl/free_addr_ram.sv
// Simple dual-port sync RAM holding free block addresses.
// It has one write port and one read port with a registered read. The array is not reset.
module free_addr_ram #(
  parameter int AW    = 12,
  parameter int DEPTH = 4096,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          iClk,
  input  logic          i_we,
  input  logic [PW-1:0] i_waddr,
  input  logic [AW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [PW-1:0] i_raddr,
  output logic [AW-1:0] o_rdata
);
  logic [AW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rdata;

  // Read data only updates on a read, so it doubles as the offered-address register.
  always_ff @(posedge iClk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/free_addr_mgr.sv
// Free-list manager: a circular FIFO of unused block addresses, filled with 0..DEPTH-1
// after reset. It prefetches into the RAM read register so allocation can run at one pop per cycle.
module free_addr_mgr
  import free_addr_mgr_pkg::*;
#(
  parameter int AW    = FA_AW,
  parameter int DEPTH = FA_DEPTH
) (
  input  logic          iClk,
  input  logic          iRst,
  output logic [AW-1:0] oEptyAddr,
  output logic          oEptyAddrVld,
  input  logic          iEptyAddrRcvRdy,
  input  logic [AW-1:0] iFreeAddr,
  input  logic          iFreeAddrVld,
  output logic          oFreeAddrRdy,
  output logic [AW:0]   oFreeCnt,
  output logic          oInitDone,
  output logic          oOvfErr
);
  localparam int PW = $clog2(DEPTH);

  fa_state_e     r_state, w_state_nxt;
  logic [PW-1:0] r_init_cnt, r_rd_ptr, r_wr_ptr;
  logic [AW:0]   r_ram_cnt;
  logic          r_vld, r_ovf;

  logic          w_run, w_init_last, w_pop, w_rd, w_push, w_full;
  logic [AW:0]   w_cnt;
  logic          w_we;
  logic [PW-1:0] w_waddr;
  logic [AW-1:0] w_wdata, w_rdata;

  assign w_run       = (r_state == FA_RUN);
  assign w_init_last = (r_state == FA_INIT) && (r_init_cnt == PW'(DEPTH-1));
  assign w_pop       = r_vld & iEptyAddrRcvRdy;
  // Refill the output whenever it is empty or being taken this cycle.
  assign w_rd        = w_run && (r_ram_cnt != '0) && (!r_vld || w_pop);
  assign w_cnt       = r_ram_cnt + (AW+1)'(r_vld);
  assign w_full      = (w_cnt >= (AW+1)'(DEPTH));
  assign w_push      = iFreeAddrVld & oFreeAddrRdy;

  always_comb begin
    w_we    = w_push;
    w_waddr = r_wr_ptr;
    w_wdata = iFreeAddr;
    if (r_state == FA_INIT) begin
      w_we    = 1'b1;
      w_waddr = r_init_cnt;
      w_wdata = AW'(r_init_cnt);
    end
  end

  free_addr_ram #(.AW(AW), .DEPTH(DEPTH), .PW(PW)) u_ram (
    .iClk    (iClk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rd),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FA_INIT: if (w_init_last) w_state_nxt = FA_RUN;
      FA_RUN:  w_state_nxt = FA_RUN;
      default: w_state_nxt = FA_INIT;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= FA_INIT;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_init_cnt <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_vld      <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (r_state == FA_INIT) begin
      r_init_cnt <= r_init_cnt + PW'(1);
      if (w_init_last) begin
        r_wr_ptr  <= '0;
        r_ram_cnt <= (AW+1)'(DEPTH);
      end
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd)   r_rd_ptr <= r_rd_ptr + PW'(1);
      r_ram_cnt <= r_ram_cnt + (AW+1)'(w_push) - (AW+1)'(w_rd);
      if (w_rd)       r_vld <= 1'b1;
      else if (w_pop) r_vld <= 1'b0;
      // A release while full can only be a double free.
      if (iFreeAddrVld && w_full) r_ovf <= 1'b1;
    end
  end

  assign oEptyAddr    = r_vld ? w_rdata : '0;
  assign oEptyAddrVld = r_vld;
  assign oFreeAddrRdy = w_run & ~w_full;
  assign oFreeCnt     = w_run ? w_cnt : '0;
  assign oInitDone    = w_run;
  assign oOvfErr      = r_ovf;
endmodule
